life_cell: RTL and testbench

One Game-of-Life cell: a registered live/dead bit that advances one generation per `tick` strobe using the standard B3/S23 rule on its eight neighbour bits. It sits directly upstream of the zero-neighbour detector and the count logic of the eight surrounding cells, because its `alive` output drives one neighbour input of each. It also consumes the eight `alive` bits of those neighbours. It adds an edit/seed mode, a saturating age counter, a change flag, and a stability FSM used by the board controller to detect a settled pattern.

---
 rtl/life_pkg.sv | 9 +
 rtl/life_cell_if.sv | 12 +
 rtl/life_cell_nbr_rule.sv | 16 +
 rtl/life_cell.sv | 98 +++++++++
 tb/tb_life_cell.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// Shared types and rule constants for the Game-of-Life cell array.
package life_pkg;
  typedef enum logic [1:0] {CELL_EDIT, CELL_RUN, CELL_STABLE} cell_state_e;

  localparam int NBR_W       = 4;
  localparam int NBR_N       = 8;
  localparam int BIRTH_CNT   = 3;
  localparam int SURVIVE_CNT = 2;
endpackage

// File: rtl/life_cell_if.sv
// Cell-side bundle: neighbour bits and board controls in, cell state out.
interface life_cell_if #(parameter int AGE_W = 4) ();
  logic             l, la, a, ra, r, rb, b, lb;
  logic             run, tick, seed_we, seed_val, clear;
  logic             alive, changed, stable;
  logic [AGE_W-1:0] age;

  modport master (output l, la, a, ra, r, rb, b, lb, run, tick, seed_we, seed_val, clear,
                  input  alive, age, changed, stable);
  modport slave  (input  l, la, a, ra, r, rb, b, lb, run, tick, seed_we, seed_val, clear,
                  output alive, age, changed, stable);
endinterface

// File: rtl/life_cell_nbr_rule.sv
// Combinational B3/S23 rule: neighbour population count and next live state.
module nbr_rule
  import life_pkg::*;
(
  input  logic [NBR_N-1:0] nbr,
  input  logic             alive,
  output logic [NBR_W-1:0] cnt,
  output logic             nxt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NBR_N; i++) cnt = cnt + NBR_W'(nbr[i]);
  end

  assign nxt = (cnt == NBR_W'(BIRTH_CNT)) | (alive & (cnt == NBR_W'(SURVIVE_CNT)));
endmodule

// File: rtl/life_cell.sv
// One Game-of-Life cell with seed/edit mode, saturating age, change flag and
// a stability FSM the board controller polls to detect a settled pattern.
module life_cell
  import life_pkg::*;
#(
  parameter bit SEED        = 1'b0,
  parameter int AGE_W       = 4,
  parameter int STABLE_GENS = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  life_cell_if.slave   io
);
  localparam int               SCNT_W  = $clog2(STABLE_GENS + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  cell_state_e       state_q, state_d;
  logic              alive_q, alive_d, changed_q, changed_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [NBR_W-1:0]  cnt;
  logic              nxt, flip, evolving;

  nbr_rule u_rule (
    .nbr   ({io.l, io.la, io.a, io.ra, io.r, io.rb, io.b, io.lb}),
    .alive (alive_q),
    .cnt   (cnt),
    .nxt   (nxt)
  );

  assign evolving = (state_q != CELL_EDIT);
  assign flip     = (nxt != alive_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CELL_EDIT;
      alive_q   <= SEED;
      age_q     <= '0;
      changed_q <= 1'b0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      age_q     <= age_d;
      changed_q <= changed_d;
      scnt_q    <= scnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alive_d   = alive_q;
    age_d     = age_q;
    changed_d = changed_q;
    scnt_d    = scnt_q;
    assert (cnt <= NBR_W'(NBR_N));
    if (io.clear) begin
      alive_d   = SEED;
      age_d     = '0;
      changed_d = 1'b0;
      scnt_d    = '0;
      state_d   = io.run ? CELL_RUN : CELL_EDIT;
    end else begin
      if (evolving && io.tick) begin
        alive_d   = nxt;
        changed_d = flip;
        if (!nxt || !alive_q)     age_d = '0;
        else if (age_q != AGE_MAX) age_d = age_q + AGE_W'(1);
        if (flip)                                 scnt_d = '0;
        else if (scnt_q != SCNT_W'(STABLE_GENS))  scnt_d = scnt_q + SCNT_W'(1);
      end else if (!evolving && io.seed_we) begin
        alive_d   = io.seed_val;
        age_d     = '0;
        changed_d = 1'b0;
        scnt_d    = '0;
      end
      case (state_q)
        CELL_EDIT:   if (io.run) state_d = CELL_RUN;
        CELL_RUN:    if (io.tick && !flip && scnt_q == SCNT_W'(STABLE_GENS - 1)) state_d = CELL_STABLE;
        CELL_STABLE: if (io.tick && flip) state_d = CELL_RUN;
        default:     state_d = CELL_EDIT;
      endcase
      // Leaving evolution drops history but keeps the pattern and its ages.
      if (!io.run) begin
        state_d = CELL_EDIT;
        if (evolving) begin
          changed_d = 1'b0;
          scnt_d    = '0;
        end
      end
    end
  end

  assign io.alive   = alive_q;
  assign io.age     = age_q;
  assign io.changed = changed_q;
  assign io.stable  = (state_q == CELL_STABLE);
endmodule

// File: tb/tb_life_cell.sv
// Directed bench for life_cell: reset, edit, birth/death, aging, stability, edge cases.
module tb_life_cell;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  life_cell_if #(.AGE_W(4)) io ();

  life_cell #(.SEED(1'b0), .AGE_W(4), .STABLE_GENS(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // order: l, la, a, ra, r, rb, b, lb
  task automatic nbr(input logic [7:0] v);
    {io.l, io.la, io.a, io.ra, io.r, io.rb, io.b, io.lb} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [7:0] N_NONE  = 8'b0000_0000;
  localparam logic [7:0] N_LAR   = 8'b1010_1000; // l, a, r
  localparam logic [7:0] N_ALL   = 8'b1111_1111;
  localparam logic [7:0] N_LARB  = 8'b0100_0100; // la, rb
  localparam logic [7:0] N_LARBA = 8'b0110_0100; // la, rb, a
  localparam logic [7:0] N_FOUR  = 8'b1110_0100; // l, la, a, rb

  initial begin
    nbr(N_NONE);
    io.run = 0; io.tick = 0; io.seed_we = 0; io.seed_val = 0; io.clear = 0;
    #12;
    chk("rst_alive", io.alive, 0);
    chk("rst_age", io.age, 0);
    chk("rst_changed", io.changed, 0);
    chk("rst_stable", io.stable, 0);
    reset_n = 1;
    step();

    // five generations, then asynchronous reset between edges
    io.run = 1; step();
    nbr(N_LAR); io.tick = 1;
    repeat (5) step();
    io.tick = 0;
    chk("gen5_alive", io.alive, 1);
    chk("gen5_age", io.age, 4);
    chk("gen5_stable", io.stable, 1);
    #2 reset_n = 0;
    #1;
    chk("arst_alive", io.alive, 0);
    chk("arst_age", io.age, 0);
    chk("arst_stable", io.stable, 0);
    io.run = 0; nbr(N_NONE);
    step();
    reset_n = 1;
    step();

    // edit mode: seed, then a tick is ignored
    io.seed_we = 1; io.seed_val = 1; step();
    io.seed_we = 0;
    chk("seed_alive", io.alive, 1);
    io.tick = 1; step();
    io.tick = 0;
    chk("edit_tick_alive", io.alive, 1);
    chk("edit_tick_changed", io.changed, 0);

    // birth and death
    io.seed_we = 1; io.seed_val = 0; step();
    io.seed_we = 0;
    chk("seed0_alive", io.alive, 0);
    io.run = 1; step();
    nbr(N_LAR); io.tick = 1; step();
    chk("birth_alive", io.alive, 1);
    chk("birth_changed", io.changed, 1);
    chk("birth_age", io.age, 0);
    nbr(N_ALL); step();
    chk("crowd_alive", io.alive, 0);
    chk("crowd_age", io.age, 0);
    nbr(N_LAR); step();
    chk("reborn_alive", io.alive, 1);
    nbr(N_NONE); step();
    chk("lonely_alive", io.alive, 0);
    chk("lonely_changed", io.changed, 1);

    // survival, aging to saturation, stability
    nbr(N_LAR); step();
    chk("surv_birth", io.alive, 1);
    nbr(N_LARB);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("age_%0d", i), io.age, (i < 15) ? i : 15);
      chk($sformatf("stable_%0d", i), io.stable, (i >= 3) ? 1 : 0);
    end
    nbr(N_LARBA); step();
    chk("cnt3_alive", io.alive, 1);
    chk("cnt3_changed", io.changed, 0);
    chk("cnt3_stable", io.stable, 1);
    nbr(N_FOUR); step();
    chk("cnt4_alive", io.alive, 0);
    chk("cnt4_changed", io.changed, 1);
    chk("cnt4_stable", io.stable, 0);
    chk("cnt4_age", io.age, 0);

    // clear beats tick; state stays RUN
    nbr(N_LAR); step();
    chk("pre_clear_alive", io.alive, 1);
    io.clear = 1; step();
    io.clear = 0;
    chk("clear_alive", io.alive, 0);
    chk("clear_changed", io.changed, 0);
    chk("clear_age", io.age, 0);
    step();
    chk("post_clear_run", io.alive, 1);
    chk("post_clear_changed", io.changed, 1);

    // run falls with tick: generation applied, then EDIT
    nbr(N_NONE); io.run = 0; step();
    chk("runfall_alive", io.alive, 0);
    chk("runfall_changed", io.changed, 0);
    chk("runfall_stable", io.stable, 0);
    nbr(N_LAR); step();
    chk("edit_ignore_alive", io.alive, 0);
    chk("edit_ignore_changed", io.changed, 0);

    // run rises with tick: that tick only enters RUN
    io.run = 1; step();
    chk("runrise_alive", io.alive, 0);
    step();
    chk("runrise_next_alive", io.alive, 1);
    chk("runrise_next_changed", io.changed, 1);
    io.tick = 0; io.run = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
